instruction_fetch: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline, directly upstream of decode. Holds the PC,

---
 rtl/instruction_fetch_pkg.sv | 14 +
 rtl/instruction_fetch_memory.sv | 26 ++
 rtl/instruction_fetch.sv | 128 ++++++++++++
 tb/tb_instruction_fetch.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: instruction encodings
// and the fetch FSM state codes.
package instruction_fetch_pkg;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_memory.sv
// Instruction memory for the fetch stage: synchronous write port used by the
// program loader, asynchronous read port used by the fetch path.
module instruction_fetch_memory #(
    parameter int len     = 32,
    parameter int NB_addr = 10
) (
    input  logic               clk,
    input  logic               we,
    input  logic [NB_addr-1:0] waddr,
    input  logic [len-1:0]     wdata,
    input  logic [NB_addr-1:0] raddr,
    output logic [len-1:0]     rdata
);

    logic [len-1:0] mem [2**NB_addr];

    // Contents are deliberately never reset so a program survives a pipeline reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, next-PC selection, load/run/halt FSM and the IF/ID
// pipeline register feeding decode.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int          len       = 32,
    parameter int          NB_addr   = 10,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_enable,
    input  logic               in_start,
    input  logic               in_prog_we,
    input  logic [NB_addr-1:0] in_prog_addr,
    input  logic [len-1:0]     in_prog_data,
    input  logic               in_branch_taken,
    input  logic [len-1:0]     in_pc_branch_target,
    input  logic               in_flag_jump,
    input  logic [len-1:0]     in_pc_jump,
    input  logic               in_flag_jump_register,
    input  logic [len-1:0]     in_pc_jump_register,
    input  logic               in_stall,
    output logic [len-1:0]     out_pc_branch,
    output logic [len-1:0]     out_instruccion,
    output logic               out_flush,
    output logic               out_halt_flag,
    output logic [len-1:0]     out_pc,
    output logic [1:0]         out_state
);

    localparam logic [len-1:0] PC_ONE  = {{(len-1){1'b0}}, 1'b1};
    localparam logic [len-1:0] PC_ZERO = '0;
    localparam logic [len-1:0] NOP     = NOP_WORD[len-1:0];
    localparam logic [len-1:0] HALT    = HALT_WORD[len-1:0];

    fetch_state_t   state;
    logic [len-1:0] pc;
    logic [len-1:0] pc_inc;
    logic [len-1:0] fetched;
    logic           mem_we;

    // Loader writes are honoured only while loading, even when the stage is frozen.
    assign mem_we = in_prog_we && (state == ST_LOAD);
    assign pc_inc = pc + PC_ONE;

    instruction_fetch_memory #(
        .len     (len),
        .NB_addr (NB_addr)
    ) u_imem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (in_prog_addr),
        .wdata (in_prog_data),
        .raddr (pc[NB_addr-1:0]),
        .rdata (fetched)
    );

    assign out_flush = in_branch_taken & in_enable;
    assign out_pc    = pc;
    assign out_state = state;

    // A branch in HALT means the halt came from a wrong path, so fetch resumes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_LOAD;
            pc              <= PC_ZERO;
            out_pc_branch   <= PC_ZERO;
            out_instruccion <= NOP;
            out_halt_flag   <= 1'b0;
        end else if (in_enable) begin
            case (state)
                ST_LOAD: begin
                    out_pc_branch   <= PC_ZERO;
                    out_instruccion <= NOP;
                    out_halt_flag   <= 1'b0;
                    if (in_start) begin
                        state <= ST_RUN;
                        pc    <= PC_ZERO;
                    end
                end
                ST_RUN: begin
                    if (in_branch_taken) begin
                        pc              <= in_pc_branch_target;
                        out_pc_branch   <= PC_ZERO;
                        out_instruccion <= NOP;
                    end else if (in_stall) begin
                        pc <= pc;
                    end else if (in_flag_jump_register) begin
                        pc              <= in_pc_jump_register;
                        out_pc_branch   <= PC_ZERO;
                        out_instruccion <= NOP;
                    end else if (in_flag_jump) begin
                        pc              <= in_pc_jump;
                        out_pc_branch   <= PC_ZERO;
                        out_instruccion <= NOP;
                    end else if (fetched == HALT) begin
                        out_pc_branch   <= pc_inc;
                        out_instruccion <= fetched;
                        out_halt_flag   <= 1'b1;
                        state           <= ST_HALT;
                    end else begin
                        pc              <= pc_inc;
                        out_pc_branch   <= pc_inc;
                        out_instruccion <= fetched;
                    end
                end
                ST_HALT: begin
                    out_pc_branch   <= PC_ZERO;
                    out_instruccion <= NOP;
                    if (in_start) begin
                        pc            <= PC_ZERO;
                        out_halt_flag <= 1'b0;
                        state         <= ST_RUN;
                    end else if (in_branch_taken) begin
                        pc            <= in_pc_branch_target;
                        out_halt_flag <= 1'b0;
                        state         <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch: load, run, stall,
// redirects, halt and reset behaviour with hand-computed expectations.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        in_enable;
    logic        in_start;
    logic        in_prog_we;
    logic [9:0]  in_prog_addr;
    logic [31:0] in_prog_data;
    logic        in_branch_taken;
    logic [31:0] in_pc_branch_target;
    logic        in_flag_jump;
    logic [31:0] in_pc_jump;
    logic        in_flag_jump_register;
    logic [31:0] in_pc_jump_register;
    logic        in_stall;
    logic [31:0] out_pc_branch;
    logic [31:0] out_instruccion;
    logic        out_flush;
    logic        out_halt_flag;
    logic [31:0] out_pc;
    logic [1:0]  out_state;

    int passCount;
    int checkCount;

    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    instruction_fetch dut (
        .clk                   (clk),
        .reset                 (reset),
        .in_enable             (in_enable),
        .in_start              (in_start),
        .in_prog_we            (in_prog_we),
        .in_prog_addr          (in_prog_addr),
        .in_prog_data          (in_prog_data),
        .in_branch_taken       (in_branch_taken),
        .in_pc_branch_target   (in_pc_branch_target),
        .in_flag_jump          (in_flag_jump),
        .in_pc_jump            (in_pc_jump),
        .in_flag_jump_register (in_flag_jump_register),
        .in_pc_jump_register   (in_pc_jump_register),
        .in_stall              (in_stall),
        .out_pc_branch         (out_pc_branch),
        .out_instruccion       (out_instruccion),
        .out_flush             (out_flush),
        .out_halt_flag         (out_halt_flag),
        .out_pc                (out_pc),
        .out_state             (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: word i holds A000_0000+i, with halts planted at 3 and 0x12.
    function automatic logic [31:0] progWord(input int i);
        if (i == 3 || i == 'h12) return HALTW;
        return 32'hA000_0000 + 32'(i);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic checkFetch(input string tag, input logic [31:0] pcb, input logic [31:0] instr,
                              input logic [31:0] pc);
        checkOutput({tag, ".pc_branch"}, out_pc_branch, pcb);
        checkOutput({tag, ".instr"}, out_instruccion, instr);
        checkOutput({tag, ".pc"}, out_pc, pc);
    endtask

    task automatic applyStimulus(input logic br, input logic [31:0] brT, input logic stall,
                                 input logic jr, input logic [31:0] jrT,
                                 input logic j, input logic [31:0] jT);
        in_branch_taken       = br;
        in_pc_branch_target   = brT;
        in_stall              = stall;
        in_flag_jump_register = jr;
        in_pc_jump_register   = jrT;
        in_flag_jump          = j;
        in_pc_jump            = jT;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        reset        = 1'b0;
        in_enable    = 1'b1;
        in_start     = 1'b0;
        in_prog_we   = 1'b0;
        in_prog_addr = '0;
        in_prog_data = '0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        #12;
        checkFetch("reset", 32'h0, 32'h0, 32'h0);
        checkOutput("reset.halt", 32'(out_halt_flag), 32'h0);
        checkOutput("reset.state", 32'(out_state), 32'h0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 'h50; i++) begin
            in_prog_we   = 1'b1;
            in_prog_addr = 10'(i);
            in_prog_data = progWord(i);
            tick();
        end
        in_prog_we = 1'b0;
        checkFetch("load.idle", 32'h0, 32'h0, 32'h0);
        checkOutput("load.state", 32'(out_state), 32'h0);

        in_enable = 1'b0;
        in_start  = 1'b1;
        tick();
        checkOutput("start.frozen.state", 32'(out_state), 32'h0);
        in_enable = 1'b1;
        tick();
        in_start = 1'b0;
        checkOutput("start.state", 32'(out_state), 32'h1);
        checkFetch("start", 32'h0, 32'h0, 32'h0);

        // Loader write while running must be ignored (checked later at 0x11)
        in_prog_we   = 1'b1;
        in_prog_addr = 10'h11;
        in_prog_data = 32'hDEAD_BEEF;
        tick();
        in_prog_we = 1'b0;
        checkFetch("seq1", 32'h1, 32'hA000_0000, 32'h1);
        tick();
        checkFetch("seq2", 32'h2, 32'hA000_0001, 32'h2);
        tick();
        checkFetch("seq3", 32'h3, 32'hA000_0002, 32'h3);
        tick();
        checkFetch("halt.fetch", 32'h4, HALTW, 32'h3);
        checkOutput("halt.flag", 32'(out_halt_flag), 32'h1);
        checkOutput("halt.state", 32'(out_state), 32'h2);
        tick();
        checkFetch("halt.hold", 32'h0, 32'h0, 32'h3);
        checkOutput("halt.hold.flag", 32'(out_halt_flag), 32'h1);

        applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("flush.on", 32'(out_flush), 32'h1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkFetch("halt.branch", 32'h0, 32'h0, 32'h4);
        checkOutput("halt.branch.flag", 32'(out_halt_flag), 32'h0);
        checkOutput("halt.branch.state", 32'(out_state), 32'h1);
        tick();
        checkFetch("pre.stall", 32'h5, 32'hA000_0004, 32'h5);

        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        checkFetch("stall1", 32'h5, 32'hA000_0004, 32'h5);
        tick();
        checkFetch("stall2", 32'h5, 32'hA000_0004, 32'h5);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        checkFetch("stall.resume", 32'h6, 32'hA000_0005, 32'h6);

        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        checkFetch("start.in.run", 32'h7, 32'hA000_0006, 32'h7);

        in_enable = 1'b0;
        applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("flush.disabled", 32'(out_flush), 32'h0);
        tick();
        checkFetch("enable.freeze", 32'h7, 32'hA000_0006, 32'h7);
        in_enable = 1'b1;

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkFetch("jump", 32'h0, 32'h0, 32'h20);
        tick();
        checkFetch("jump.fetch", 32'h21, 32'hA000_0020, 32'h21);

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h30, 1'b1, 32'h38);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkFetch("jr.over.j", 32'h0, 32'h0, 32'h30);
        tick();
        checkFetch("jr.fetch", 32'h31, 32'hA000_0030, 32'h31);

        applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20);
        #1;
        checkOutput("prio.flush", 32'(out_flush), 32'h1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkFetch("prio.branch", 32'h0, 32'h0, 32'h40);
        tick();
        checkFetch("prio.fetch", 32'h41, 32'hA000_0040, 32'h41);

        applyStimulus(1'b1, 32'h12, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkFetch("to.halt2", 32'h0, 32'h0, 32'h12);
        tick();
        checkFetch("halt2.fetch", 32'h13, HALTW, 32'h12);
        checkOutput("halt2.flag", 32'(out_halt_flag), 32'h1);
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkFetch("wrongpath", 32'h0, 32'h0, 32'h10);
        checkOutput("wrongpath.flag", 32'(out_halt_flag), 32'h0);
        checkOutput("wrongpath.state", 32'(out_state), 32'h1);
        tick();
        checkFetch("wrongpath.fetch", 32'h11, 32'hA000_0010, 32'h11);
        tick();
        checkFetch("we.ignored", 32'h12, 32'hA000_0011, 32'h12);

        #2;
        reset = 1'b0;
        #1;
        checkFetch("midreset", 32'h0, 32'h0, 32'h0);
        checkOutput("midreset.halt", 32'(out_halt_flag), 32'h0);
        checkOutput("midreset.state", 32'(out_state), 32'h0);
        reset = 1'b1;
        tick();
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        checkOutput("replay.state", 32'(out_state), 32'h1);
        tick();
        checkFetch("replay1", 32'h1, 32'hA000_0000, 32'h1);
        tick();
        checkFetch("replay2", 32'h2, 32'hA000_0001, 32'h2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
